// File: rtl/wb_regfile_fwd_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_fwd_if
// Purpose  : Writeback request/acknowledge bus between the writeback stage
//            (master) and the pending-write register file (slave).
// Signals  : wb_req  - writeback request valid (master -> slave)
//            wb_ack  - slave can accept this cycle (slave -> master)
//            wb_we   - transfer carries a register write (0 = bubble)
//            wb_addr - destination register
//            wb_data - write data
// Revision : 1.0 - initial release
// ============================================================================
interface wb_regfile_fwd_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              wb_req;
  logic              wb_ack;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (output wb_req, output wb_we, output wb_addr, output wb_data,
                  input  wb_ack);
  modport slave  (input  wb_req, input  wb_we, input  wb_addr, input  wb_data,
                  output wb_ack);
endinterface
`default_nettype wire

// File: rtl/wb_regfile_fwd.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_fwd
// Purpose  : Writeback buffer + register file. Writeback results arrive over
//            a req/ack bus into a DEPTH-entry in-order buffer that drains one
//            entry per cycle into a NUM_REGS x DATA_W array. Two combinational
//            read ports, optionally forwarding from entries not yet drained.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            wb (slave modport)   - writeback req/ack/we/addr/data
//            wr_stall             - array write port busy, hold the drain
//            rd_addr_a/rd_data_a  - read port A
//            rd_addr_b/rd_data_b  - read port B
//            fifo_level, busy     - pending entry count, level != 0
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_fwd #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 16,
  parameter  int DEPTH    = 4,
  parameter  int ZERO_REG = 1,
  parameter  int FWD_EN   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  wb_regfile_fwd_if.slave        wb,
  input  wire logic              wr_stall,
  input  wire logic [ADDR_W-1:0] rd_addr_a,
  output logic      [DATA_W-1:0] rd_data_a,
  input  wire logic [ADDR_W-1:0] rd_addr_b,
  output logic      [DATA_W-1:0] rd_data_b,
  output logic      [LVL_W-1:0]  fifo_level,
  output logic                   busy
);

  localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  C_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]  C_LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem    [NUM_REGS];
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [LVL_W-1:0]  r_level;

  logic w_full;
  logic w_ack;
  logic w_zero_dst;
  logic w_push;
  logic w_pop;

  // No pass-through: a full buffer refuses even when it drains this cycle.
  assign w_full     = (r_level == C_LVL_FULL);
  assign w_ack      = !w_full && !reset;
  assign wb.wb_ack  = w_ack;
  assign w_zero_dst = (ZERO_REG != 0) && (wb.wb_addr == '0);
  // Bubbles and writes to the hardwired zero register complete without a slot.
  assign w_push     = wb.wb_req && w_ack && wb.wb_we && !w_zero_dst;
  assign w_pop      = (r_level != '0) && !wr_stall;

  assign fifo_level = r_level;
  assign busy       = (r_level != '0);

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_pop) begin
        r_mem[r_q_addr[r_head]] <= r_q_data[r_head];
        r_head                  <= f_next_ptr(r_head);
      end
      if (w_push) begin
        r_q_addr[r_tail] <= wb.wb_addr;
        r_q_data[r_tail] <= wb.wb_data;
        r_tail           <= f_next_ptr(r_tail);
      end
      if (w_push && !w_pop)
        r_level <= r_level + 1'b1;
      else if (!w_push && w_pop)
        r_level <= r_level - 1'b1;
    end
  end

  // Walk the pending entries oldest to youngest so the last match wins,
  // giving the youngest pending write to the address.
  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    int                k;
    v = r_mem[a];
    if (FWD_EN != 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        k = int'(r_head) + i;
        if (k >= DEPTH) k = k - DEPTH;
        if ((i < int'(r_level)) && (r_q_addr[PTR_W'(k)] == a))
          v = r_q_data[PTR_W'(k)];
      end
    end
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rd_data_a = f_read(rd_addr_a);
    rd_data_b = f_read(rd_addr_b);
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile_fwd
// Purpose  : Self-checking bench. Instance 0 uses the default parameters
//            (DEPTH=4, ZERO_REG=1, FWD_EN=1); instance 1 uses DEPTH=3,
//            ZERO_REG=0, FWD_EN=0. Both see the same stimulus and are compared
//            against a queue-based reference model of each configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_fwd;
  logic        clk = 1'b0;
  logic        reset = 1'b1, req = 1'b0, we = 1'b0, stall = 1'b0;
  logic [3:0]  addr = '0, ra = '0, rb = '0;
  logic [15:0] data = '0;
  logic        ack0, ack1, busy0, busy1;
  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic [2:0]  lvl0;
  logic [1:0]  lvl1;
  int          n_chk = 0, n_fail = 0;

  // Reference model: architectural array plus an ordered list of pending
  // writes (index 0 = oldest) for each configuration.
  logic [15:0] m_mem [2][16];
  logic [3:0]  m_qa  [2][4];
  logic [15:0] m_qd  [2][4];
  int          m_cnt [2];

  always #5 clk = ~clk;

  wb_regfile_fwd_if #(.ADDR_W(4), .DATA_W(16)) if0 ();
  wb_regfile_fwd_if #(.ADDR_W(4), .DATA_W(16)) if1 ();
  assign if0.wb_req = req;  assign if0.wb_we = we;
  assign if0.wb_addr = addr; assign if0.wb_data = data;
  assign if1.wb_req = req;  assign if1.wb_we = we;
  assign if1.wb_addr = addr; assign if1.wb_data = data;
  assign ack0 = if0.wb_ack;
  assign ack1 = if1.wb_ack;

  wb_regfile_fwd dut0 (
    .clk(clk), .reset(reset), .wb(if0), .wr_stall(stall),
    .rd_addr_a(ra), .rd_data_a(rda0), .rd_addr_b(rb), .rd_data_b(rdb0),
    .fifo_level(lvl0), .busy(busy0));

  wb_regfile_fwd #(.DEPTH(3), .ZERO_REG(0), .FWD_EN(0)) dut1 (
    .clk(clk), .reset(reset), .wb(if1), .wr_stall(stall),
    .rd_addr_a(ra), .rd_data_a(rda1), .rd_addr_b(rb), .rd_data_b(rdb1),
    .fifo_level(lvl1), .busy(busy1));

  function automatic int m_depth(int n); return (n == 0) ? 4 : 3; endfunction
  function automatic bit m_zero(int n);  return (n == 0);          endfunction
  function automatic bit m_fwd(int n);   return (n == 0);          endfunction

  function automatic logic [15:0] m_read(int n, logic [3:0] a);
    if (m_zero(n) && a == 4'd0) return 16'h0000;
    if (m_fwd(n))
      for (int i = m_cnt[n] - 1; i >= 0; i--)
        if (m_qa[n][i] == a) return m_qd[n][i];
    return m_mem[n][a];
  endfunction

  function automatic bit m_ack(int n);
    return !reset && (m_cnt[n] < m_depth(n));
  endfunction

  task automatic m_update();
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        for (int a = 0; a < 16; a++) m_mem[n][a] = 16'h0000;
        m_cnt[n] = 0;
      end else begin
        bit acc;
        acc = req && (m_cnt[n] < m_depth(n)) && we && !(m_zero(n) && addr == 4'd0);
        if (m_cnt[n] > 0 && !stall) begin
          m_mem[n][m_qa[n][0]] = m_qd[n][0];
          for (int i = 0; i < 3; i++) begin
            m_qa[n][i] = m_qa[n][i+1];
            m_qd[n][i] = m_qd[n][i+1];
          end
          m_cnt[n]--;
        end
        if (acc) begin
          m_qa[n][m_cnt[n]] = addr;
          m_qd[n][m_cnt[n]] = data;
          m_cnt[n]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 4'd3; data = 16'hDEAD; stall = 1'b0;
    #1;
    n_chk++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack0 got=%0h exp=0", ack0); end
    n_chk++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack1 got=%0h exp=0", ack1); end
    tick(); tick();
    reset = 1'b0; req = 1'b0;
    #1;
    n_chk++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack0 got=%0h exp=1", ack0); end
    n_chk++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack1 got=%0h exp=1", ack1); end
    n_chk++; if (lvl0 !== 3'd0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_level0 got=%0d/%0h exp=0/0", lvl0, busy0); end
    n_chk++; if (lvl1 !== 2'd0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_level1 got=%0d/%0h exp=0/0", lvl1, busy1); end
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a); rb = 4'(15 - a);
      #1;
      n_chk++;
      if (rda0 !== 16'h0 || rdb0 !== 16'h0 || rda1 !== 16'h0 || rdb1 !== 16'h0) begin
        n_fail++; $display("FAIL reset_read r%0d got=%h/%h/%h/%h exp=0", a, rda0, rdb0, rda1, rdb1);
      end
    end
  endtask

  task automatic test_single_write();
    req = 1'b1; we = 1'b1; addr = 4'd3; data = 16'h1234; stall = 1'b0; ra = 4'd3;
    #1;
    n_chk++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL t2_ack got=%0h exp=1", ack0); end
    tick();
    req = 1'b0;
    #1;
    n_chk++; if (rda0 !== 16'h1234) begin n_fail++; $display("FAIL t2_fwd got=%h exp=1234", rda0); end
    n_chk++; if (lvl0 !== 3'd1) begin n_fail++; $display("FAIL t2_level got=%0d exp=1", lvl0); end
    n_chk++; if (rda1 !== 16'h0000) begin n_fail++; $display("FAIL t2_nofwd_stale got=%h exp=0000", rda1); end
    tick();
    n_chk++; if (rda0 !== 16'h1234 || lvl0 !== 3'd0) begin n_fail++; $display("FAIL t2_drained got=%h/%0d exp=1234/0", rda0, lvl0); end
    n_chk++; if (rda1 !== 16'h1234) begin n_fail++; $display("FAIL t2_nofwd_drained got=%h exp=1234", rda1); end
  endtask

  task automatic test_same_addr_stalled();
    stall = 1'b1; req = 1'b1; we = 1'b1; addr = 4'd5; ra = 4'd5;
    for (int v = 1; v <= 3; v++) begin
      data = 16'(v);
      tick();
    end
    req = 1'b0;
    #1;
    n_chk++; if (rda0 !== 16'h0003 || lvl0 !== 3'd3) begin n_fail++; $display("FAIL t3_youngest got=%h/%0d exp=0003/3", rda0, lvl0); end
    n_chk++; if (rda1 !== 16'h0000 || lvl1 !== 2'd3) begin n_fail++; $display("FAIL t3_nofwd got=%h/%0d exp=0000/3", rda1, lvl1); end
    stall = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (lvl0 !== 3'd0 || rda0 !== 16'h0003) begin n_fail++; $display("FAIL t3_drained got=%0d/%h exp=0/0003", lvl0, rda0); end
    n_chk++; if (rda1 !== 16'h0003) begin n_fail++; $display("FAIL t3_array1 got=%h exp=0003", rda1); end
  endtask

  task automatic test_full();
    stall = 1'b1; req = 1'b1; we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr = 4'(8 + k); data = 16'(16'hA000 + k);
      #1;
      n_chk++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL t4_ack%0d got=%0h exp=1", k, ack0); end
      tick();
    end
    addr = 4'd12; data = 16'hA004;
    #1;
    n_chk++; if (lvl0 !== 3'd4 || ack0 !== 1'b0) begin n_fail++; $display("FAIL t4_full got=%0d/%0h exp=4/0", lvl0, ack0); end
    tick();
    n_chk++; if (lvl0 !== 3'd4 || ack0 !== 1'b0) begin n_fail++; $display("FAIL t4_held got=%0d/%0h exp=4/0", lvl0, ack0); end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    n_chk++; if (lvl0 !== 3'd3 || ack0 !== 1'b1) begin n_fail++; $display("FAIL t4_one_pop got=%0d/%0h exp=3/1", lvl0, ack0); end
    tick();
    req = 1'b0;
    #1;
    n_chk++; if (lvl0 !== 3'd4) begin n_fail++; $display("FAIL t4_fifth got=%0d exp=4", lvl0); end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_chk++; if (lvl0 !== 3'd0 || lvl1 !== 2'd0) begin n_fail++; $display("FAIL t4_empty got=%0d/%0d exp=0/0", lvl0, lvl1); end
    for (int k = 0; k < 5; k++) begin
      ra = 4'(8 + k); rb = 4'(8 + k);
      #1;
      n_chk++; if (rda0 !== 16'(16'hA000 + k)) begin n_fail++; $display("FAIL t4_data r%0d got=%h exp=%h", 8 + k, rda0, 16'hA000 + k); end
      n_chk++; if (rdb1 !== m_read(1, rb)) begin n_fail++; $display("FAIL t4_data1 r%0d got=%h exp=%h", 8 + k, rdb1, m_read(1, rb)); end
    end
  endtask

  task automatic test_zero_reg();
    stall = 1'b0; req = 1'b1; we = 1'b1; addr = 4'd0; data = 16'hFFFF; ra = 4'd0;
    #1;
    n_chk++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL t5_ack got=%0h exp=1", ack0); end
    tick();
    req = 1'b0;
    #1;
    n_chk++; if (lvl0 !== 3'd0 || rda0 !== 16'h0000) begin n_fail++; $display("FAIL t5_r0 got=%0d/%h exp=0/0000", lvl0, rda0); end
    n_chk++; if (lvl1 !== 2'd1) begin n_fail++; $display("FAIL t5_level1 got=%0d exp=1", lvl1); end
    tick();
    n_chk++; if (rda1 !== 16'hFFFF) begin n_fail++; $display("FAIL t5_r0_ordinary got=%h exp=ffff", rda1); end
  endtask

  task automatic test_reset_discard();
    logic [3:0] regs [3];
    regs[0] = 4'd1; regs[1] = 4'd2; regs[2] = 4'd7;
    stall = 1'b1; req = 1'b1; we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr = regs[k]; data = 16'(16'h1111 * (k + 1));
      tick();
    end
    reset = 1'b1; addr = 4'd4; data = 16'h4444;
    #1;
    n_chk++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL t6_ack_in_reset got=%0h exp=0", ack0); end
    tick();
    reset = 1'b0; req = 1'b0; stall = 1'b0;
    #1;
    n_chk++; if (lvl0 !== 3'd0 || lvl1 !== 2'd0) begin n_fail++; $display("FAIL t6_level got=%0d/%0d exp=0/0", lvl0, lvl1); end
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 3; k++) begin
      ra = regs[k]; rb = regs[k];
      #1;
      n_chk++; if (rda0 !== 16'h0 || rdb1 !== 16'h0) begin n_fail++; $display("FAIL t6_discard r%0d got=%h/%h exp=0", regs[k], rda0, rdb1); end
    end
  endtask

  task automatic test_wrap();
    req = 1'b1; we = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int b;
      b = 0;
      addr = 4'(k + 1); data = 16'(16'hC000 + k * 17);
      #1;
      while (ack1 !== 1'b1 && b < 20) begin
        stall = 1'b0; tick(); b++;
      end
      n_chk++; if (b >= 20) begin n_fail++; $display("FAIL wrap_timeout k=%0d got=ack %0h exp=1", k, ack1); end
      stall = 1'($urandom_range(0, 1));
      tick();
    end
    req = 1'b0; stall = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_chk++; if (lvl1 !== 2'd0 || lvl0 !== 3'd0) begin n_fail++; $display("FAIL wrap_empty got=%0d/%0d exp=0/0", lvl1, lvl0); end
    for (int k = 0; k < 10; k++) begin
      ra = 4'(k + 1); rb = 4'(k + 1);
      #1;
      n_chk++; if (rda1 !== 16'(16'hC000 + k * 17)) begin n_fail++; $display("FAIL wrap_data1 r%0d got=%h exp=%h", k + 1, rda1, 16'(16'hC000 + k * 17)); end
      n_chk++; if (rdb0 !== 16'(16'hC000 + k * 17)) begin n_fail++; $display("FAIL wrap_data0 r%0d got=%h exp=%h", k + 1, rdb0, 16'(16'hC000 + k * 17)); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      req   = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 7) != 0);
      addr  = 4'($urandom_range(0, 7));
      data  = 16'($urandom);
      stall = ($urandom_range(0, 4) < 2);
      ra    = 4'($urandom_range(0, 8));
      rb    = 4'($urandom_range(0, 15));
      #1;
      n_chk++; if (ack0 !== m_ack(0) || ack1 !== m_ack(1)) begin n_fail++; $display("FAIL rnd_ack c=%0d got=%0h/%0h exp=%0h/%0h", c, ack0, ack1, m_ack(0), m_ack(1)); end
      n_chk++; if (lvl0 !== 3'(m_cnt[0]) || busy0 !== (m_cnt[0] != 0)) begin n_fail++; $display("FAIL rnd_level0 c=%0d got=%0d exp=%0d", c, lvl0, m_cnt[0]); end
      n_chk++; if (lvl1 !== 2'(m_cnt[1]) || busy1 !== (m_cnt[1] != 0)) begin n_fail++; $display("FAIL rnd_level1 c=%0d got=%0d exp=%0d", c, lvl1, m_cnt[1]); end
      n_chk++; if (rda0 !== m_read(0, ra) || rdb0 !== m_read(0, rb)) begin n_fail++; $display("FAIL rnd_read0 c=%0d got=%h/%h exp=%h/%h", c, rda0, rdb0, m_read(0, ra), m_read(0, rb)); end
      n_chk++; if (rda1 !== m_read(1, ra) || rdb1 !== m_read(1, rb)) begin n_fail++; $display("FAIL rnd_read1 c=%0d got=%h/%h exp=%h/%h", c, rda1, rdb1, m_read(1, ra), m_read(1, rb)); end
      tick();
    end
    reset = 1'b0; req = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_same_addr_stalled();
    test_full();
    test_zero_reg();
    test_reset_discard();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit exceeded");
  end
endmodule
`default_nettype wire
